// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one SRAM-like port between the fetch and data
// requesters. One transaction is outstanding at a time. Data has priority
// over fetch, except that a fetch which has lost STARVE_LIMIT arbitrations
// in a row wins the next one. A fetch cancel drops the in-flight inst
// response while letting the memory transaction finish normally.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // memory port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic             owner_inst_q, owner_inst_d;   // 1 = fetch owns the port
    logic             drop_q, drop_d;               // discard pending inst response
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             win_inst;

    // State and latched-request registers; synchronous reset back to idle ARB
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            owner_inst_q <= 1'b0;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state, arbitration decision and handshake outputs
    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        win_inst     = 1'b0;

        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            ARB: begin
                if (inst_req || data_req) begin
                    win_inst     = inst_req && (!data_req || starve_cnt_q == LIMIT);
                    owner_inst_d = win_inst;
                    drop_d       = 1'b0;
                    state_d      = REQ;
                    if (win_inst) begin
                        // fetches are always reads
                        addr_d       = inst_addr;
                        wr_d         = 1'b0;
                        wstrb_d      = '0;
                        wdata_d      = '0;
                        starve_cnt_d = '0;
                    end else begin
                        addr_d  = data_addr;
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        wdata_d = data_wdata;
                        if (inst_req && starve_cnt_q != LIMIT)
                            starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_wr    = wr_q;
                mem_wstrb = wstrb_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (inst_cancel && owner_inst_q)
                    drop_d = 1'b1;
                if (mem_addr_ok) begin
                    inst_addr_ok = owner_inst_q;
                    data_addr_ok = !owner_inst_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    // a cancel arriving together with the response still kills it
                    if (owner_inst_q) begin
                        inst_data_ok = !drop_q && !inst_cancel;
                        inst_rdata   = mem_rdata;
                    end else begin
                        data_data_ok = 1'b1;
                        data_rdata   = mem_rdata;
                    end
                    drop_d  = 1'b0;
                    state_d = ARB;
                end else if (inst_cancel && owner_inst_q) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        // hold every output quiet while reset is asserted
        if (reset) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = '0;
            mem_req      = 1'b0;
            mem_wr       = 1'b0;
            mem_wstrb    = '0;
            mem_addr     = '0;
            mem_wdata    = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios driven by a single process,
// a per-cycle compare against a transaction-level model, and literal checks
// of grant order, latencies and read data.
module tb_mem_port_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    int n_chk = 0, n_fail = 0;

    // requesters: number of requests still to be issued
    int inst_left = 0, data_left = 0;
    bit acc_i, acc_d;
    // memory responder
    int mph = 0, mcnt = 0, aw = 0, dw = 0;
    logic [31:0] resp_data = 32'h0;
    // observed events
    int cyc, t_iaok, t_idok, t_daok, t_ddok, n_idok, n_ddok;
    int gq[$];
    logic [31:0] rd_i, rd_d, cap_addr, cap_wdata;
    logic        cap_wr;
    logic [3:0]  cap_wstrb;
    // model: phase 0 idle / 1 request on port / 2 awaiting response
    int          m_ph = 0, m_starve = 0;
    bit          m_inst = 1'b0, m_drop = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic        m_wr = 1'b0;
    logic [3:0]  m_wstrb = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_ev();
        cyc = 0; t_iaok = 0; t_idok = 0; t_daok = 0; t_ddok = 0;
        n_idok = 0; n_ddok = 0; gq.delete();
    endtask

    // One clock: compare at negedge, model update at posedge, drive at +1
    task automatic tick();
        logic ei_a, ei_d, ed_a, ed_d, e_req;
        @(negedge clk);
        cyc++;
        if (reset) begin
            chk("reset_oks", 32'({mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_wr}), 32'h0);
            chk("reset_mem_addr", mem_addr, 32'h0);
            chk("reset_mem_wdata", mem_wdata, 32'h0);
            chk("reset_mem_wstrb", 32'(mem_wstrb), 32'h0);
        end else begin
            e_req = (m_ph == 1);
            ei_a  = (m_ph == 1) && m_inst && mem_addr_ok;
            ed_a  = (m_ph == 1) && !m_inst && mem_addr_ok;
            ei_d  = (m_ph == 2) && m_inst && mem_data_ok && !m_drop && !inst_cancel;
            ed_d  = (m_ph == 2) && !m_inst && mem_data_ok;
            chk("oks", 32'({mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}),
                32'({e_req, ei_a, ei_d, ed_a, ed_d}));
            if (e_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wr_wstrb", 32'({mem_wr, mem_wstrb}), 32'({m_wr, m_wstrb}));
                if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (ei_d) chk("inst_rdata", inst_rdata, mem_rdata);
            if (ed_d) chk("data_rdata", data_rdata, mem_rdata);
        end
        if (inst_addr_ok) begin t_iaok = cyc; gq.push_back(1); acc_i = 1'b1; end
        if (data_addr_ok) begin t_daok = cyc; gq.push_back(0); acc_d = 1'b1; end
        if (inst_data_ok) begin t_idok = cyc; n_idok++; rd_i = inst_rdata; end
        if (data_data_ok) begin t_ddok = cyc; n_ddok++; rd_d = data_rdata; end
        if (mem_req) begin cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wr = mem_wr; cap_wstrb = mem_wstrb; end

        @(posedge clk);
        if (reset) begin
            m_ph = 0; m_inst = 1'b0; m_drop = 1'b0; m_starve = 0;
        end else begin
            case (m_ph)
                0: if (inst_req || data_req) begin
                    if (inst_req && (!data_req || m_starve == LIM)) begin
                        m_inst = 1'b1; m_starve = 0;
                        m_addr = inst_addr; m_wr = 1'b0; m_wstrb = 4'h0;
                    end else begin
                        m_inst = 1'b0;
                        if (inst_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
                        m_addr = data_addr; m_wr = data_wr; m_wstrb = data_wstrb; m_wdata = data_wdata;
                    end
                    m_drop = 1'b0; m_ph = 1;
                end
                1: begin
                    if (inst_cancel && m_inst) m_drop = 1'b1;
                    if (mem_addr_ok) m_ph = 2;
                end
                default: begin
                    if (mem_data_ok) begin m_ph = 0; m_drop = 1'b0; end
                    else if (inst_cancel && m_inst) m_drop = 1'b1;
                end
            endcase
        end

        #1;
        if (acc_i) inst_left--;
        if (acc_d) data_left--;
        acc_i = 1'b0; acc_d = 1'b0;
        inst_req = (inst_left > 0) && !reset;
        data_req = (data_left > 0) && !reset;
        if (reset) begin
            mph = 0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        end else begin
            case (mph)
                0: begin
                    mem_data_ok = 1'b0;
                    if (mem_req) begin
                        if (aw == 0) begin mem_addr_ok = 1'b1; mph = 2; mcnt = dw; end
                        else begin mem_addr_ok = 1'b0; mcnt = aw - 1; mph = 1; end
                    end else mem_addr_ok = 1'b0;
                end
                1: if (mcnt == 0) begin mem_addr_ok = 1'b1; mph = 2; mcnt = dw; end
                   else mcnt--;
                2: begin
                    mem_addr_ok = 1'b0;
                    if (mcnt == 0) begin mem_data_ok = 1'b1; mem_rdata = resp_data; mph = 3; end
                    else mcnt--;
                end
                default: begin mem_data_ok = 1'b0; mph = 0; end
            endcase
        end
    endtask

    task automatic wait_idle(input string nm, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick();
            done = (inst_left == 0) && (data_left == 0) && (mph == 0) && !mem_req && (m_ph == 0);
        end
        chk({nm, "_idle_reached"}, 32'(done), 32'h1);
    endtask

    task automatic chk_gq(input string nm, input int e[$]);
        chk({nm, "_grants"}, 32'(gq.size()), 32'(e.size()));
        if (gq.size() == e.size())
            for (int i = 0; i < e.size(); i++) chk({nm, "_grant"}, 32'(gq[i]), 32'(e[i]));
    endtask

    initial begin
        int e[$];
        bit seen;
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        acc_i = 1'b0; acc_d = 1'b0;
        clear_ev();
        @(posedge clk); #1;
        tick(); tick();
        chk("reset_model_starve", 32'(m_starve), 32'h0);
        reset = 1'b0;

        // single fetch, zero-wait memory
        clear_ev(); aw = 0; dw = 0;
        inst_addr = 32'h1c000000; resp_data = 32'h02800c0c;
        inst_left = 1; inst_req = 1'b1;
        wait_idle("fetch", 40);
        chk("fetch_addr_ok_cycle", 32'(t_iaok), 32'd2);
        chk("fetch_data_ok_cycle", 32'(t_idok), 32'd3);
        chk("fetch_rdata", rd_i, 32'h02800c0c);
        chk("fetch_no_data_ok", 32'(n_ddok + n_idok), 32'd1);
        chk("fetch_mem_addr", cap_addr, 32'h1c000000);

        // contention: data first, fetch at the following arbitration
        clear_ev();
        data_wr = 1'b0; data_addr = 32'h1c001000; inst_addr = 32'h1c000040;
        resp_data = 32'h11112222;
        inst_left = 1; data_left = 1; inst_req = 1'b1; data_req = 1'b1;
        wait_idle("contend", 40);
        e = {0, 1}; chk_gq("contend", e);
        chk("contend_data_accept_cycle", 32'(t_daok), 32'd2);
        chk("contend_back_to_back", 32'(t_iaok - t_daok), 32'd3);
        chk("contend_rdata", rd_d, 32'h11112222);
        chk("contend_starve_cleared", 32'(m_starve), 32'h0);

        // starvation: four data wins then the fetch
        clear_ev(); resp_data = 32'h0000c0de;
        data_left = 6; inst_left = 1; data_req = 1'b1; inst_req = 1'b1;
        wait_idle("starve", 100);
        e = {0, 0, 0, 0, 1, 0, 0}; chk_gq("starve", e);

        // write pass-through with a one-cycle response wait
        clear_ev(); dw = 1;
        data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h1c002004; data_wdata = 32'hdeadbeef;
        data_left = 1; data_req = 1'b1;
        wait_idle("write", 40);
        chk("write_mem_wr", 32'(cap_wr), 32'h1);
        chk("write_mem_wstrb", 32'(cap_wstrb), 32'h3);
        chk("write_mem_addr", cap_addr, 32'h1c002004);
        chk("write_mem_wdata", cap_wdata, 32'hdeadbeef);
        chk("write_ack_count", 32'(n_ddok), 32'd1);
        chk("write_ack_cycle", 32'(t_ddok), 32'd4);
        data_wr = 1'b0; data_wstrb = 4'h0;

        // flush during RESP, response arrives later and is dropped
        clear_ev(); dw = 3; inst_addr = 32'h1c000100; resp_data = 32'h55aa55aa;
        inst_left = 1; inst_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (t_iaok != 0); end
        chk("flush_accept_seen", 32'(seen), 32'h1);
        inst_cancel = 1'b1; tick(); inst_cancel = 1'b0;
        wait_idle("flush", 40);
        chk("flush_no_inst_data_ok", 32'(n_idok), 32'd0);

        // fetch after flush is served normally
        clear_ev(); dw = 0; resp_data = 32'h0badf00d;
        inst_left = 1; inst_req = 1'b1;
        wait_idle("post_flush", 40);
        chk("post_flush_count", 32'(n_idok), 32'd1);
        chk("post_flush_rdata", rd_i, 32'h0badf00d);
        chk("post_flush_data_ok_cycle", 32'(t_idok), 32'd3);

        // cancel in the same cycle as the inst response
        clear_ev(); dw = 0; resp_data = 32'h12345678;
        inst_left = 1; inst_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (t_iaok != 0); end
        chk("same_cycle_accept_seen", 32'(seen), 32'h1);
        inst_cancel = 1'b1; tick(); inst_cancel = 1'b0;
        wait_idle("same_cycle_cancel", 40);
        chk("same_cycle_cancel_dropped", 32'(n_idok), 32'd0);

        // reset while a data read waits in RESP, with a fetch losing once
        clear_ev(); dw = 10; data_addr = 32'h1c003000;
        data_left = 1; inst_left = 1; data_req = 1'b1; inst_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (t_daok != 0); end
        chk("rst_accept_seen", 32'(seen), 32'h1);
        tick();
        chk("rst_model_starve_before", 32'(m_starve), 32'h1);
        reset = 1'b1; inst_left = 0; data_left = 0; inst_req = 1'b0; data_req = 1'b0;
        tick();
        chk("rst_outputs", 32'({mem_req, mem_wr, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_model_starve_after", 32'(m_starve), 32'h0);
        reset = 1'b0;
        // starve counter really cleared: four data wins before the fetch again
        clear_ev(); dw = 0;
        data_left = 5; inst_left = 1; data_req = 1'b1; inst_req = 1'b1;
        wait_idle("post_reset", 100);
        e = {0, 0, 0, 0, 1, 0}; chk_gq("post_reset", e);
        chk("post_reset_first_accept_cycle", 32'(t_daok != 0), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the instruction-fetch requester (pre-IF/IF) and the data requester (EX/MEM).
- Serialises accesses with one outstanding transaction at a time.
- Gives data priority over fetch, with starvation protection for fetch.
- Supports a fetch cancel on pipeline flush (exception/ertn), dropping the stale instruction response.

Parameters:
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending fetch wins over data.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_cancel  in  1  flush; discard any in-flight fetch response
- inst_addr_ok  out  1  fetch request accepted by memory
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte write enables
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid (read data or write ack)
- data_rdata  out  32  data read data
- mem_req  out  1  memory request
- mem_wr  out  1  memory write
- mem_wstrb  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- States are ARB, REQ and RESP. Reset puts the FSM in ARB, owner=data, drop=0, starve_cnt=0.
- Outputs during reset: all *_ok outputs 0, mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr/mem_wdata 0.
- ARB:
  - Both requesters idle: stay in ARB.
  - Otherwise pick a winner: fetch if (inst_req && (!data_req || starve_cnt==STARVE_LIMIT)); else data if data_req.
  - Latch owner and the winner's addr/wr/wstrb/wdata into registers; go to REQ next cycle.
  - An inst request never writes: latch wr=0, wstrb=0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each ARB decision where inst_req=1 and data wins.
  - Cleared when fetch wins.
  - Unchanged when no decision is made.
- REQ:
  - mem_req=1, mem_* driven from the latched registers.
  - On mem_addr_ok: pulse the owner's *_addr_ok for that same cycle (combinational from mem_addr_ok), then go to RESP.
  - Non-owner *_addr_ok stays 0.
- RESP:
  - mem_req=0. Wait for mem_data_ok.
  - Same cycle as mem_data_ok: the owner's *_data_ok=1 and *_rdata=mem_rdata (combinational pass-through). Suppress inst_data_ok if drop is set or inst_cancel is high in that cycle.
  - Next state is ARB, drop cleared.
- rdata outside a valid data_ok cycle is don't-care; the bench must only sample it with data_ok.
- Minimum transaction: ARB→REQ→RESP gives 3 cycles with zero-wait memory, so the earliest back-to-back accepts are 3 cycles apart.
- inst_cancel:
  - In REQ or RESP with owner=inst: set drop. The transaction still completes on the memory side; requests are never withdrawn.
  - In ARB: no state effect.
  - With owner=data: ignored.
- Simultaneous events:
  - mem_addr_ok and mem_data_ok in the same REQ cycle: illegal (memory guarantees the response arrives ≥1 cycle after accept); need not be handled.
  - inst_cancel in the same cycle as mem_data_ok for an inst response: response dropped.
- Reset mid-transaction returns to ARB immediately. The outstanding memory response is the environment's responsibility (memory is reset together with the arbiter).

Test Plan:
- Single fetch: inst_req=1, addr=0x1c000000, memory answers addr_ok after 0 cycles and data_ok 1 cycle later with 0x02800c0c → inst_addr_ok pulse at cycle 2, inst_data_ok + inst_rdata=0x02800c0c at cycle 3; data_* stay 0.
- Contention: inst_req and data_req (read, 0x1c001000) both high from cycle 0 → data is granted first; inst is granted at the following ARB, and starve_cnt returns to 0 after the inst grant.
- Starvation: data_req held high continuously with inst_req high → data wins 4 consecutive arbitrations (STARVE_LIMIT=4); the 5th arbitration grants inst.
- Write pass-through: data_wr=1, wstrb=4'b0011, addr=0x1c002004, wdata=0xdeadbeef → mem_wr=1, mem_wstrb=0011, mem_addr/mem_wdata match; data_data_ok pulses on the ack.
- Flush: inst transaction accepted, inst_cancel pulsed one cycle during RESP, mem_data_ok 3 cycles later → inst_data_ok never asserts; FSM back in ARB, and a new inst_req is served normally.
- Reset in RESP: assert reset while waiting for data_ok → next cycle: state ARB, all outputs 0, starve_cnt=0.
